// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter owning a shared register bank: one read or write per clock,
// with registered grant, read data, read-valid and served-requester index.
module dff_bank_arbiter #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 8,
  parameter  int ADDR_W = 3,
  parameter  int NREQ   = 4,
  localparam int RID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ-1:0]          lock,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*WIDTH-1:0]    wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rvalid,
  output logic [RID_W-1:0]         rid
);

  logic [WIDTH-1:0]  bank [DEPTH];
  logic [RID_W-1:0]  ptr;
  logic [RID_W-1:0]  win;
  logic              found;
  logic [RID_W-1:0]  ptr_next;
  logic [NREQ-1:0]   onehot;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [WIDTH-1:0]  sel_wdata;

  // Circular search starting at ptr; the first requester found wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        win   = RID_W'((int'(ptr) + k) % NREQ);
      end
    end
  end

  // Only the winner's request fields are observed; losers' inputs are ignored.
  always_comb begin
    sel_addr  = addr[int'(win)*ADDR_W +: ADDR_W];
    sel_we    = we[win];
    sel_wdata = wdata[int'(win)*WIDTH +: WIDTH];
    onehot    = '0;
    onehot[win] = 1'b1;
    if (lock[win])
      ptr_next = win;
    else if (int'(win) == NREQ - 1)
      ptr_next = '0;
    else
      ptr_next = win + 1'b1;
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // read of bank/ptr in this block sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the bank is a register file, not a RAM macro, so it is cleared
      // on reset like any other flop.
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
      ptr    <= '0;
      gnt    <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
      rid    <= '0;
    end else begin
      gnt    <= '0;
      rvalid <= 1'b0;
      if (found) begin
        gnt <= onehot;
        rid <= win;
        ptr <= ptr_next;
        if (sel_we) begin
          bank[sel_addr] <= sel_wdata;
        end else begin
          rdata  <= bank[sel_addr];
          rvalid <= 1'b1;
        end
      end
    end
  end

endmodule
